// File: rtl/conv2d_stream_core.sv
// Streaming KSxKS signed 2-D convolution with KS-1 line buffers, one pixel per clock.
// Three-stage multiply / sum / bias-shift-saturate pipeline behind a single valid/ready enable.
module conv2d_stream_core #(
  parameter int KS    = 3,
  parameter int DW    = 16,
  parameter int WW    = 16,
  parameter int MAX_W = 256,
  parameter int CW    = 9,
  parameter int AW    = DW + WW + $clog2(KS * KS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   param_ena,
  input  logic [KS*KS*WW-1:0]    param_weight,
  input  logic [AW-1:0]          param_bias,
  input  logic [5:0]             param_shift,
  input  logic [CW-1:0]          param_width,
  input  logic [CW-1:0]          param_height,
  output logic                   param_err,
  input  logic                   pxl_valid,
  input  logic [DW-1:0]          pxl_data,
  output logic                   pxl_ready,
  output logic                   out_valid,
  output logic [DW-1:0]          out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int LBA = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int PW  = DW + WW;

  logic [1:0]                state;
  logic [KS*KS*WW-1:0]       weight_q;
  logic signed [AW-1:0]      bias_q;
  logic [5:0]                shift_q;
  logic [CW-1:0]             w_q, h_q, row, col;
  logic signed [DW-1:0]      win [KS][KS];
  logic signed [DW-1:0]      lb [KS-1][MAX_W];
  logic signed [DW-1:0]      col_in [KS];
  logic signed [PW-1:0]      prod_p1 [KS*KS];
  logic signed [AW-1:0]      sum_p2;
  logic signed [AW-1:0]      sum_c;
  logic signed [AW:0]        biased_c;
  logic                      vld_p0, vld_p1, vld_p2;
  logic                      en, accept, geom_ok, last_pix, last_out;

  function automatic logic signed [AW:0] shift_floor(input logic signed [AW:0] v,
                                                     input logic [5:0] s);
    return v >>> s;
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [AW:0] v);
    if (v[AW:DW-1] == {(AW-DW+2){v[AW]}})
      return v[DW-1:0];
    else if (v[AW])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  assign en        = !out_valid || out_ready;
  assign pxl_ready = (state == RUN) && en;
  assign accept    = pxl_valid && pxl_ready;
  assign busy      = (state != IDLE);
  assign geom_ok   = (32'(param_width) >= KS) && (32'(param_width) <= MAX_W) &&
                     (32'(param_height) >= KS);
  assign last_pix  = (row == h_q - 1'b1) && (col == w_q - 1'b1);
  // Nothing left in flight once DRAIN is entered except what the valid bits show.
  assign last_out  = (state == DRAIN) && out_valid && out_ready && !vld_p0 && !vld_p1 && !vld_p2;

  always_comb begin
    for (int r = 0; r < KS - 1; r++) col_in[r] = lb[r][col[LBA-1:0]];
    col_in[KS-1] = $signed(pxl_data);
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < KS * KS; k++) sum_c = sum_c + AW'(prod_p1[k]);
  end

  assign biased_c = $signed({sum_p2[AW-1], sum_p2}) + $signed({bias_q[AW-1], bias_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      param_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      param_err  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (param_ena) begin
            if (geom_ok) begin
              state <= RUN;
              row   <= '0;
              col   <= '0;
            end else begin
              param_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (col == w_q - 1'b1) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_out) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // stage p0: window column loaded; p1: products; p2: sum; output: bias/shift/saturate
      if (en) begin
        vld_p0    <= accept && (32'(row) >= KS - 1) && (32'(col) >= KS - 1);
        vld_p1    <= vld_p0;
        vld_p2    <= vld_p1;
        out_valid <= vld_p2;
        out_data  <= saturate(shift_floor(biased_c, shift_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && param_ena && geom_ok) begin
      weight_q <= param_weight;
      bias_q   <= $signed(param_bias);
      shift_q  <= param_shift;
      w_q      <= param_width;
      h_q      <= param_height;
    end
    // stage p0: window shift and line-buffer chain, each buffer passes its pixel one row up
    if (accept) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS - 1; c++) win[r][c] <= win[r][c+1];
        win[r][KS-1] <= col_in[r];
      end
      for (int r = 0; r < KS - 1; r++) lb[r][col[LBA-1:0]] <= col_in[r+1];
    end
    // stage p1 / p2
    if (en) begin
      for (int k = 0; k < KS * KS; k++)
        prod_p1[k] <= win[k / KS][k % KS] * $signed(weight_q[k*WW +: WW]);
      sum_p2 <= sum_c;
    end
  end

endmodule
